// File: rtl/cache_burst_counter.sv
// Beat sequencer for one cache-line refill or write-back burst.
// Supports partial bursts, critical-word-first wrap, stall, abort and a done pulse.
module cache_burst_counter #(
  parameter  int unsigned BEATS = 4,
  localparam int unsigned IDX_W = $clog2(BEATS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wrap_en,
  input  logic [IDX_W-1:0] start_off,
  input  logic [IDX_W-1:0] len_m1,
  input  logic             beat_ok,
  input  logic             stop,
  input  logic             abort,
  output logic             busy,
  output logic [IDX_W-1:0] idx,
  output logic [IDX_W-1:0] beat_cnt,
  output logic             last,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] len_q, len_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             last_c;

  // Final beat is decoded from registers only, so there is no input-to-output path.
  assign last_c = (state_q == RUN) && (cnt_q == len_q);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and datapath; priority in RUN is abort, then stop, then beat_ok.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
        if (start) begin
          state_d = RUN;
          idx_d   = wrap_en ? start_off : '0;
          len_d   = len_m1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (!stop && beat_ok) begin
          // The final beat's index and count stay visible through DONE.
          if (last_c) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = cnt_q + IDX_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign idx      = idx_q;
  assign beat_cnt = cnt_q;
  assign last     = last_c;

endmodule

// File: tb/tb_cache_burst_counter.sv
// Directed bench for cache_burst_counter: table of per-cycle vectors on a 4-beat
// instance plus hand sequences for the 8-beat wrap/back-to-back and async reset cases.
module tb_cache_burst_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, wrap_en, beat_ok, stop, abort;
  logic [2:0] start_off, len_m1;

  logic       busy4, last4, done4;
  logic [1:0] idx4, cnt4;
  logic       busy8, last8, done8;
  logic [2:0] idx8, cnt8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_burst_counter #(.BEATS(4)) u4 (
    .clk(clk), .rst(rst), .start(start), .wrap_en(wrap_en),
    .start_off(start_off[1:0]), .len_m1(len_m1[1:0]),
    .beat_ok(beat_ok), .stop(stop), .abort(abort),
    .busy(busy4), .idx(idx4), .beat_cnt(cnt4), .last(last4), .done(done4)
  );

  cache_burst_counter #(.BEATS(8)) u8 (
    .clk(clk), .rst(rst), .start(start), .wrap_en(wrap_en),
    .start_off(start_off), .len_m1(len_m1),
    .beat_ok(beat_ok), .stop(stop), .abort(abort),
    .busy(busy8), .idx(idx8), .beat_cnt(cnt8), .last(last8), .done(done8)
  );

  typedef struct {
    logic       start, wrap_en;
    logic [2:0] off, len;
    logic       beat_ok, stop, abort;
    logic       busy;
    logic [1:0] idx, cnt;
    logic       last, done;
  } vec_t;

  vec_t vecs [64];
  int   nvec = 0;

  task automatic add(input logic s, input logic w, input logic [2:0] o, input logic [2:0] l,
                     input logic bo, input logic st, input logic ab,
                     input logic b, input logic [1:0] i, input logic [1:0] c,
                     input logic la, input logic d);
    vecs[nvec] = '{s, w, o, l, bo, st, ab, b, i, c, la, d};
    nvec++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic w, input logic [2:0] o, input logic [2:0] l,
                       input logic bo, input logic st, input logic ab);
    start = s; wrap_en = w; start_off = o; len_m1 = l;
    beat_ok = bo; stop = st; abort = ab;
  endtask

  task automatic chk4(input string tag, input logic b, input int i, input int c,
                      input logic la, input logic d);
    chk({tag, ".busy"}, int'(busy4), int'(b));
    chk({tag, ".idx"},  int'(idx4),  i);
    chk({tag, ".cnt"},  int'(cnt4),  c);
    chk({tag, ".last"}, int'(last4), int'(la));
    chk({tag, ".done"}, int'(done4), int'(d));
  endtask

  task automatic chk8(input string tag, input logic b, input int i, input int c,
                      input logic la, input logic d);
    chk({tag, ".busy"}, int'(busy8), int'(b));
    chk({tag, ".idx"},  int'(idx8),  i);
    chk({tag, ".cnt"},  int'(cnt8),  c);
    chk({tag, ".last"}, int'(last8), int'(la));
    chk({tag, ".done"}, int'(done8), int'(d));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // Incremental full burst; start in RUN is ignored.
    //  s  w  off len bo st ab  | busy idx cnt last done
    add(1, 0, 0, 3, 1, 0, 0,    1, 0, 0, 0, 0);
    add(0, 0, 0, 3, 1, 0, 0,    1, 1, 1, 0, 0);
    add(1, 1, 1, 0, 1, 0, 0,    1, 2, 2, 0, 0);
    add(0, 0, 0, 3, 1, 0, 0,    1, 3, 3, 1, 0);
    add(0, 0, 0, 3, 1, 0, 0,    0, 3, 3, 0, 1);
    add(0, 0, 0, 3, 1, 0, 0,    0, 0, 0, 0, 0);
    // Wrap from offset 2; later config changes must not matter.
    add(1, 1, 2, 3, 1, 0, 0,    1, 2, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,    1, 3, 1, 0, 0);
    add(0, 0, 1, 1, 1, 0, 0,    1, 0, 2, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0,    1, 1, 3, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0,    0, 1, 3, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
    // Stall on the second beat for three cycles with beat_ok high.
    add(1, 1, 2, 3, 1, 0, 0,    1, 2, 0, 0, 0);
    add(0, 1, 2, 3, 1, 0, 0,    1, 3, 1, 0, 0);
    add(0, 1, 2, 3, 1, 1, 0,    1, 3, 1, 0, 0);
    add(0, 1, 2, 3, 1, 1, 0,    1, 3, 1, 0, 0);
    add(0, 1, 2, 3, 1, 1, 0,    1, 3, 1, 0, 0);
    add(0, 1, 2, 3, 1, 0, 0,    1, 0, 2, 0, 0);
    add(0, 1, 2, 3, 1, 0, 0,    1, 1, 3, 1, 0);
    add(0, 1, 2, 3, 0, 1, 0,    1, 1, 3, 1, 0);
    add(0, 1, 2, 3, 1, 0, 0,    0, 1, 3, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);
    // Abort with beat_ok on beat 2, then idle with no done.
    add(1, 0, 0, 3, 1, 0, 0,    1, 0, 0, 0, 0);
    add(0, 0, 0, 3, 1, 0, 0,    1, 1, 1, 0, 0);
    add(0, 0, 0, 3, 1, 1, 1,    0, 0, 0, 0, 0);
    add(0, 0, 0, 3, 1, 0, 0,    0, 0, 0, 0, 0);
    // Single-beat partial burst.
    add(1, 0, 0, 0, 0, 0, 0,    1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 0, 0,    0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0,    0, 0, 0, 0, 0);

    #2;
    chk4("reset4", 0, 0, 0, 0, 0);
    chk8("reset8", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < nvec; k++) begin
      drive(vecs[k].start, vecs[k].wrap_en, vecs[k].off, vecs[k].len,
            vecs[k].beat_ok, vecs[k].stop, vecs[k].abort);
      step();
      chk4($sformatf("vec%0d", k), vecs[k].busy, int'(vecs[k].idx), int'(vecs[k].cnt),
           vecs[k].last, vecs[k].done);
    end

    // 8-beat wrap from 6, length 3, then back-to-back single beat from the DONE cycle.
    drive(1, 1, 6, 2, 1, 0, 0); step(); chk8("w8.b0", 1, 6, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 0); step(); chk8("w8.b1", 1, 7, 1, 0, 0);
    step();                             chk8("w8.b2", 1, 0, 2, 1, 0);
    step();                             chk8("w8.done", 0, 0, 2, 0, 1);
    drive(1, 0, 5, 0, 0, 0, 0); step(); chk8("b2b.run", 1, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 0, 0); step(); chk8("b2b.done", 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0); step(); chk8("b2b.idle", 0, 0, 0, 0, 0);

    // Asynchronous reset between edges in the middle of a burst.
    drive(1, 1, 1, 3, 1, 0, 0); step(); chk4("rr.b0", 1, 1, 0, 0, 0);
    drive(0, 1, 1, 3, 1, 0, 0); step(); chk4("rr.b1", 1, 2, 1, 0, 0);
    #2 rst = 1'b1;
    #1 chk4("rst.mid", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 1, 0, 0, 0); step(); chk4("rst.start", 1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 1, 0, 0); step(); chk4("rst.b1", 1, 1, 1, 1, 0);
    step();                             chk4("rst.done", 0, 1, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0); step(); chk4("rst.idle", 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
